// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem byte address and fills
// the IF/ID register. Handles stall, flush, redirect, end-of-program halt and faults.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instruction,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instruction,
  output logic        halted,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_DEPTH);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } ifid_t;

  ifid_t       ifid_q, ifid_d;
  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic        in_range, fetch_ok, word_nz, redir_live, redir_aligned;

  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    in_range      = pc_q < PC_LIMIT;
    fetch_ok      = !halted_q && in_range;
    word_nz       = |imem_instruction;
    redir_live    = redirect_valid && !halted_q;
    redir_aligned = redirect_target[1:0] == 2'b00;

    pc_d     = pc_q;
    halted_d = halted_q;
    fault_d  = fault_q;

    // Once halted only reset restarts fetch, so redirects are ignored there.
    if (redir_live) begin
      if (redir_aligned) begin
        pc_d = redirect_target;
      end else begin
        fault_d  = 1'b1;
        halted_d = 1'b1;
      end
    end else if (halted_q) begin
      pc_d = pc_q;
    end else if (!in_range) begin
      fault_d  = 1'b1;
      halted_d = 1'b1;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (!word_nz && !flush) begin
      halted_d = 1'b1;
    end else begin
      pc_d = pc_plus4;
    end
  end

  always_comb begin
    ifid_d = ifid_q;
    cnt_d  = cnt_q;
    if (flush || redirect_valid) begin
      ifid_d.valid = 1'b0;
      ifid_d.instr = 32'h0;
    end else if (stall) begin
      ifid_d = ifid_q;
    end else if (fetch_ok && word_nz) begin
      ifid_d.valid    = 1'b1;
      ifid_d.pc       = pc_q;
      ifid_d.pc_plus4 = pc_plus4;
      ifid_d.instr    = imem_instruction;
      cnt_d           = cnt_q + 32'd1;
    end else begin
      ifid_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      ifid_q   <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= 32'h0;
    end else begin
      pc_q     <= pc_d;
      ifid_q   <= ifid_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
    end
  end

  assign imem_pc        = pc_q;
  assign id_valid       = ifid_q.valid;
  assign id_pc          = ifid_q.pc;
  assign id_pc_plus4    = ifid_q.pc_plus4;
  assign id_instruction = ifid_q.instr;
  assign halted         = halted_q;
  assign fetch_fault    = fault_q;
  assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: scenario tasks drive stimulus, a negedge monitor pops the
// scoreboard each time a new instruction lands in IF/ID.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_pc, imem_instruction;
  logic        id_valid, halted, fetch_fault;
  logic [31:0] id_pc, id_pc_plus4, id_instruction, fetch_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem [0:63];
  logic [31:0] last_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  if_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_pc(imem_pc), .imem_instruction(imem_instruction),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .id_instruction(id_instruction), .halted(halted),
    .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_instruction = (imem_pc < 32'd256) ? mem[imem_pc[7:2]] : 32'h0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_cnt = 32'h0;
    end else if (fetch_count != last_cnt) begin
      exp_t e;
      last_cnt = fetch_count;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_issue: got unexpected issue pc=%h instr=%h, want none", id_pc, id_instruction);
      end else begin
        e = sb_q.pop_front();
        if (id_valid !== 1'b1 || id_pc !== e.pc || id_instruction !== e.instr || id_pc_plus4 !== e.pc + 32'd4) begin
          n_bad++;
          $display("FAIL sb_issue: got v=%b pc=%h p4=%h instr=%h, want v=1 pc=%h p4=%h instr=%h",
                   id_valid, id_pc, id_pc_plus4, id_instruction, e.pc, e.pc + 32'd4, e.instr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    sb_q.push_back(e);
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset just released.
  task automatic do_reset();
    @(negedge clk);
    stall = 0; flush = 0; redirect_valid = 0; redirect_target = 0;
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 1;
    #1 rst_n = 0;
    #2;
    n_cmp++;
    if ({imem_pc, id_valid, id_pc, id_pc_plus4, id_instruction, halted, fetch_fault, fetch_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_vals: got pc=%h v=%b idpc=%h p4=%h ins=%h h=%b f=%b cnt=%h, want all zero",
               imem_pc, id_valid, id_pc, id_pc_plus4, id_instruction, halted, fetch_fault, fetch_count);
    end
    step();
    n_cmp++;
    if (imem_pc !== 32'h0 || id_valid !== 1'b0 || fetch_count !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_hold: got pc=%h v=%b cnt=%h, want 0 0 0", imem_pc, id_valid, fetch_count);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    push(32'h0, 32'h11); push(32'h4, 32'h22); push(32'h8, 32'h33);
    repeat (4) step();
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (halted !== 1'b1 || imem_pc !== 32'd12 || id_valid !== 1'b0 || fetch_count !== 32'd3 || fetch_fault !== 1'b0) begin
        n_bad++;
        $display("FAIL seq_halt[%0d]: got h=%b pc=%h v=%b cnt=%0d f=%b, want h=1 pc=c v=0 cnt=3 f=0",
                 i, halted, imem_pc, id_valid, fetch_count, fetch_fault);
      end
      step();
    end
    @(negedge clk); #1;
    n_cmp++;
    if (sb_q.size() != 0) begin n_bad++; $display("FAIL seq_drain: got %0d left, want 0", sb_q.size()); end
  endtask

  task automatic test_stall();
    do_reset();
    push(32'h0, 32'h11); push(32'h4, 32'h22); push(32'h8, 32'h33);
    step(); step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (imem_pc !== 32'h8 || id_pc !== 32'h4 || id_valid !== 1'b1 || fetch_count !== 32'd2) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got pc=%h idpc=%h v=%b cnt=%0d, want pc=8 idpc=4 v=1 cnt=2",
                 i, imem_pc, id_pc, id_valid, fetch_count);
      end
    end
    stall = 0;
    step();
    n_cmp++;
    if (id_pc !== 32'h8 || id_instruction !== 32'h33 || id_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_resume: got idpc=%h ins=%h v=%b, want 8 33 1", id_pc, id_instruction, id_valid);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (sb_q.size() != 0) begin n_bad++; $display("FAIL stall_drain: got %0d left, want 0", sb_q.size()); end
  endtask

  task automatic test_redirect();
    do_reset();
    push(32'h0, 32'h11);
    step();
    redirect_valid = 1; redirect_target = 32'h20;
    step();
    n_cmp++;
    if (imem_pc !== 32'h20 || id_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_bubble: got pc=%h v=%b, want 20 0", imem_pc, id_valid);
    end
    redirect_valid = 0;
    push(32'h20, 32'h88); push(32'h24, 32'h99);
    step();
    n_cmp++;
    if (id_pc !== 32'h20 || id_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL redir_target: got idpc=%h v=%b, want 20 1", id_pc, id_valid);
    end
    step(); step();
    n_cmp++;
    if (halted !== 1'b1 || fetch_count !== 32'd3 || imem_pc !== 32'h28) begin
      n_bad++;
      $display("FAIL redir_end: got h=%b cnt=%0d pc=%h, want 1 3 28", halted, fetch_count, imem_pc);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (sb_q.size() != 0) begin n_bad++; $display("FAIL redir_drain: got %0d left, want 0", sb_q.size()); end
  endtask

  task automatic test_flush_stall();
    do_reset();
    push(32'h0, 32'h11); push(32'h4, 32'h22);
    step();
    flush = 1; stall = 1;
    step();
    n_cmp++;
    if (id_valid !== 1'b0 || id_instruction !== 32'h0 || imem_pc !== 32'h4 || fetch_count !== 32'd1) begin
      n_bad++;
      $display("FAIL fs_bubble: got v=%b ins=%h pc=%h cnt=%0d, want 0 0 4 1", id_valid, id_instruction, imem_pc, fetch_count);
    end
    flush = 0; stall = 0;
    step();
    n_cmp++;
    if (id_pc !== 32'h4 || id_instruction !== 32'h22 || id_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL fs_refetch: got idpc=%h ins=%h v=%b, want 4 22 1", id_pc, id_instruction, id_valid);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (sb_q.size() != 0) begin n_bad++; $display("FAIL fs_drain: got %0d left, want 0", sb_q.size()); end
  endtask

  task automatic test_faults();
    do_reset();
    push(32'h0, 32'h11);
    step();
    redirect_valid = 1; redirect_target = 32'h22;
    step();
    n_cmp++;
    if (fetch_fault !== 1'b1 || halted !== 1'b1 || imem_pc !== 32'h4 || id_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL misalign: got f=%b h=%b pc=%h v=%b, want 1 1 4 0", fetch_fault, halted, imem_pc, id_valid);
    end
    redirect_target = 32'h20;
    step();
    redirect_valid = 0;
    step();
    n_cmp++;
    if (imem_pc !== 32'h4 || halted !== 1'b1 || fetch_fault !== 1'b1 || fetch_count !== 32'd1 || id_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_ignore: got pc=%h h=%b f=%b cnt=%0d v=%b, want 4 1 1 1 0",
               imem_pc, halted, fetch_fault, fetch_count, id_valid);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (sb_q.size() != 0) begin n_bad++; $display("FAIL fault_drain: got %0d left, want 0", sb_q.size()); end

    do_reset();
    redirect_valid = 1; redirect_target = 32'h100;
    step();
    redirect_valid = 0;
    n_cmp++;
    if (imem_pc !== 32'h100 || fetch_fault !== 1'b0 || id_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_redir: got pc=%h f=%b v=%b, want 100 0 0", imem_pc, fetch_fault, id_valid);
    end
    step();
    n_cmp++;
    if (fetch_fault !== 1'b1 || halted !== 1'b1 || id_valid !== 1'b0 || imem_pc !== 32'h100 || fetch_count !== 32'd0) begin
      n_bad++;
      $display("FAIL oor_fault: got f=%b h=%b v=%b pc=%h cnt=%0d, want 1 1 0 100 0",
               fetch_fault, halted, id_valid, imem_pc, fetch_count);
    end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({imem_pc, id_valid, id_pc, id_pc_plus4, id_instruction, halted, fetch_fault, fetch_count} !== '0) begin
      n_bad++;
      $display("FAIL async_rst: got pc=%h v=%b idpc=%h p4=%h ins=%h h=%b f=%b cnt=%h, want all zero",
               imem_pc, id_valid, id_pc, id_pc_plus4, id_instruction, halted, fetch_fault, fetch_count);
    end
    @(posedge clk); #1;
    rst_n = 1;
    push(32'h0, 32'h11);
    step();
    n_cmp++;
    if (id_pc !== 32'h0 || id_instruction !== 32'h11 || fetch_count !== 32'd1 || imem_pc !== 32'h4) begin
      n_bad++;
      $display("FAIL async_restart: got idpc=%h ins=%h cnt=%0d pc=%h, want 0 11 1 4",
               id_pc, id_instruction, fetch_count, imem_pc);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (sb_q.size() != 0) begin n_bad++; $display("FAIL async_drain: got %0d left, want 0", sb_q.size()); end
  endtask

  initial begin
    stall = 0; flush = 0; redirect_valid = 0; redirect_target = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
    mem[8] = 32'h88; mem[9] = 32'h99;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_flush_stall();
    test_faults();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
